spi_mstr_cfg: RTL and testbench

Parametrised SPI master, the next-generation replacement for the fixed 16-bit, mode-3-only master. Adds configurable word width, SCLK rate, front/back porch, all four SPI modes selected per transfer, and multiple one-hot slave selects. It sits between a register/command controller and external SPI peripherals (IMU, A2D), one transaction per `wrt` pulse.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_mstr_cfg_if.sv | 31 +++
 rtl/spi_shreg.sv | 47 ++++
 rtl/spi_mstr_cfg.sv | 174 +++++++++++++++++
 tb/tb_spi_mstr_cfg.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the configurable SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRONT,
    ST_LEAD,
    ST_TRAIL,
    ST_BACK
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bit params_ok(input int data_w, input int sclk_half,
                                   input int front, input int back,
                                   input int num_ss);
    return (data_w >= 2) && (data_w <= 64) && (sclk_half >= 2) &&
           (front >= 1) && (back >= 1) && (num_ss >= 1);
  endfunction

endpackage

// File: rtl/spi_mstr_cfg_if.sv
// Command side and SPI pin side of the master, bundled for port connection.
interface spi_mstr_cfg_if #(
  parameter int DATA_W = 16,
  parameter int NUM_SS = 1,
  parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);

  logic              wrt;
  logic [DATA_W-1:0] cmd;
  logic [SS_W-1:0]   ss_sel;
  logic              cpol;
  logic              cpha;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic [NUM_SS-1:0] SS_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  wrt, cmd, ss_sel, cpol, cpha, MISO,
    output SCLK, MOSI, SS_n, busy, done, rd_data
  );

  modport slave (
    output wrt, cmd, ss_sel, cpol, cpha, MISO,
    input  SCLK, MOSI, SS_n, busy, done, rd_data
  );

endinterface

// File: rtl/spi_shreg.sv
// Transmit/receive shift register plus the MISO sample flop; MOSI is the MSB.
module spi_shreg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              sample_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [DATA_W-1:0] data_nxt_o
);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic              smp_q, smp_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sr_d  = sr_q;
    smp_d = smp_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[DATA_W-2:0], smp_q};
    end
    if (sample_i) begin
      smp_d = miso_i;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      smp_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      smp_q <= smp_d;
    end
  end

  assign mosi_o     = sr_q[DATA_W-1];
  assign data_nxt_o = sr_d;

endmodule

// File: rtl/spi_mstr_cfg.sv
// SPI master with per-transfer mode, configurable width/rate/porches and one-hot selects.
module spi_mstr_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SCLK_HALF = 32,
  parameter int FRONT     = 2,
  parameter int BACK      = 16,
  parameter int NUM_SS    = 1,
  parameter int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mstr_cfg_if.master bus
);

  localparam int TMR_W = $clog2(max3(FRONT, SCLK_HALF, BACK));
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] FRONT_RLD = TMR_W'(FRONT - 1);
  localparam logic [TMR_W-1:0] HALF_RLD  = TMR_W'(SCLK_HALF - 1);
  localparam logic [TMR_W-1:0] BACK_RLD  = TMR_W'(BACK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);

  if (!params_ok(DATA_W, SCLK_HALF, FRONT, BACK, NUM_SS)) begin : g_param_err
    $error("spi_mstr_cfg: illegal parameter combination");
  end

  spi_state_t        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sclk_q, sclk_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              done_q, done_d;

  logic              tmr_zero, load, lead_edge, trail_edge, back_first;
  logic              sample, shift;
  logic [DATA_W-1:0] sr_nxt;

  // Out-of-range indices decode to no select at all.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] ss;
    ss = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) ss[i] = 1'b0;
    end
    return ss;
  endfunction

  assign tmr_zero   = (tmr_q == '0);
  assign load       = (state_q == ST_IDLE) && bus.wrt;
  assign lead_edge  = tmr_zero && ((state_q == ST_FRONT) || (state_q == ST_TRAIL));
  assign trail_edge = tmr_zero && (state_q == ST_LEAD);
  assign back_first = (state_q == ST_BACK) && (tmr_q == BACK_RLD);

  // cpha=1 skips the shift on the first leading edge and makes it up on entry to BACK.
  assign sample = mode_q.cpha ? trail_edge : lead_edge;
  assign shift  = mode_q.cpha ? ((lead_edge && (state_q == ST_TRAIL)) || back_first)
                              : trail_edge;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sclk_d = mode_q.cpol;
        if (bus.wrt) begin
          mode_d  = '{cpol: bus.cpol, cpha: bus.cpha};
          tmr_d   = FRONT_RLD;
          cnt_d   = CNT_LAST;
          sclk_d  = bus.cpol;
          ss_n_d  = ss_decode(bus.ss_sel);
          state_d = ST_FRONT;
        end
      end
      ST_FRONT: begin
        if (tmr_zero) begin
          sclk_d  = ~sclk_q;
          tmr_d   = HALF_RLD;
          state_d = ST_LEAD;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_LEAD: begin
        if (tmr_zero) begin
          sclk_d = ~sclk_q;
          // The back porch is timed from the last trailing edge itself.
          if (cnt_q == '0) begin
            tmr_d   = BACK_RLD;
            state_d = ST_BACK;
          end else begin
            tmr_d   = HALF_RLD;
            state_d = ST_TRAIL;
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_TRAIL: begin
        if (tmr_zero) begin
          cnt_d   = cnt_q - CNT_ONE;
          sclk_d  = ~sclk_q;
          tmr_d   = HALF_RLD;
          state_d = ST_LEAD;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_BACK: begin
        if (tmr_zero) begin
          ss_n_d  = '1;
          done_d  = 1'b1;
          rd_d    = sr_nxt;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      ss_n_q  <= '1;
      mode_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  spi_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .shift_i    (shift),
    .sample_i   (sample),
    .load_data_i(bus.cmd),
    .miso_i     (bus.MISO),
    .mosi_o     (bus.MOSI),
    .data_nxt_o (sr_nxt)
  );

  assign bus.SCLK    = sclk_q;
  assign bus.SS_n    = ss_n_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_spi_mstr_cfg.sv
// Directed bench: default-parameter loopback plus an 8-bit, 4-select instance with a slave model.
module tb_spi_mstr_cfg;

  localparam int XFER_BUDGET = 200;
  localparam int B_LAT       = 2 + 15 * 2 + 2;
  localparam int A_LAT       = 2 + 32 * 32 + 16 - 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  spi_mstr_cfg_if #(.DATA_W(16), .NUM_SS(1))            a_if ();
  spi_mstr_cfg_if #(.DATA_W(8),  .NUM_SS(4), .SS_W(3))  b_if ();

  spi_mstr_cfg #(
    .DATA_W(16), .SCLK_HALF(32), .FRONT(2), .BACK(16), .NUM_SS(1)
  ) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if.master)
  );

  spi_mstr_cfg #(
    .DATA_W(8), .SCLK_HALF(2), .FRONT(2), .BACK(2), .NUM_SS(4), .SS_W(3)
  ) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if.master)
  );

  assign a_if.MISO = a_if.MOSI;

  // Mode-matched slave on instance b, evaluated on the falling clk edge.
  logic       sl_cpol = 1'b0, sl_cpha = 1'b0;
  logic [7:0] sl_word = 8'h00, sl_tx = 8'h00, sl_rx = 8'h00;
  logic       sl_prev_act = 1'b0, sl_prev_sclk = 1'b0;
  wire        sl_act = ~&b_if.SS_n;

  always @(negedge clk) begin
    sl_prev_act  <= sl_act;
    sl_prev_sclk <= b_if.SCLK;
    if (!rst_n) begin
      b_if.MISO <= 1'b0;
    end else if (sl_act && !sl_prev_act) begin
      sl_rx <= 8'h00;
      if (!sl_cpha) begin
        b_if.MISO <= sl_word[7];
        sl_tx     <= {sl_word[6:0], 1'b0};
      end else begin
        sl_tx <= sl_word;
      end
    end else if (sl_act && (b_if.SCLK != sl_prev_sclk)) begin
      if ((b_if.SCLK != sl_cpol) != sl_cpha) begin
        sl_rx <= {sl_rx[6:0], b_if.MOSI};
      end else begin
        b_if.MISO <= sl_tx[7];
        sl_tx     <= {sl_tx[6:0], 1'b0};
      end
    end
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [2:0] ss_sel;
    logic [7:0] cmd;
    logic [7:0] word;
    logic [3:0] exp_ss_n;
    bit         chk_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Starts a transfer on instance b from the current (falling-edge) time and waits for done.
  task automatic xfer(input vec_t v, input int repulse_at, output int lat,
                      output logic sclk_first, output logic [3:0] ss_first,
                      output logic [3:0] ss_and, output logic sclk_end,
                      output logic [3:0] ss_end, output logic [7:0] rd);
    b_if.wrt    = 1'b1;
    b_if.cmd    = v.cmd;
    b_if.ss_sel = v.ss_sel;
    b_if.cpol   = v.cpol;
    b_if.cpha   = v.cpha;
    sl_cpol     = v.cpol;
    sl_cpha     = v.cpha;
    sl_word     = v.word;
    lat        = -1;
    sclk_first = 1'b0;
    ss_first   = 4'h0;
    ss_and     = 4'hF;
    sclk_end   = 1'b0;
    ss_end     = 4'h0;
    rd         = 8'h00;
    for (int k = 0; k < XFER_BUDGET; k++) begin
      @(negedge clk);
      if (k == repulse_at) begin
        b_if.wrt    = 1'b1;
        b_if.cmd    = ~v.cmd;
        b_if.ss_sel = 3'd0;
      end else begin
        b_if.wrt = 1'b0;
      end
      if (k == 0) begin
        sclk_first = b_if.SCLK;
        ss_first   = b_if.SS_n;
      end
      if (b_if.done) begin
        lat      = k;
        sclk_end = b_if.SCLK;
        ss_end   = b_if.SS_n;
        rd       = b_if.rd_data;
        break;
      end
      ss_and &= b_if.SS_n;
    end
    b_if.wrt = 1'b0;
  endtask

  int         lat, lat2, a_lat, a_rises;
  logic       sclk_first, sclk_end, a_prev;
  logic [3:0] ss_first, ss_and, ss_end, ss_first2, ss_and2, ss_end2;
  logic [7:0] rd, rd2;
  vec_t       v_rep, v_b2b;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'd2, 8'h96, 8'h3C, 4'hB, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 3'd2, 8'h1E, 8'h3C, 4'hB, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 8'hC4, 8'h3C, 4'hB, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 3'd2, 8'h7B, 8'h3C, 4'hB, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 8'h81, 8'hA5, 4'hE, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 3'd3, 8'h42, 8'h5A, 4'h7, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 3'd5, 8'hFF, 8'h3C, 4'hF, 1'b0};

    a_if.wrt = 1'b0; a_if.cmd = '0; a_if.ss_sel = '0; a_if.cpol = 1'b0; a_if.cpha = 1'b0;
    b_if.wrt = 1'b0; b_if.cmd = '0; b_if.ss_sel = '0; b_if.cpol = 1'b0; b_if.cpha = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst a SCLK",    64'(a_if.SCLK),    64'h0);
    check("rst a MOSI",    64'(a_if.MOSI),    64'h0);
    check("rst a SS_n",    64'(a_if.SS_n),    64'h1);
    check("rst a busy",    64'(a_if.busy),    64'h0);
    check("rst a done",    64'(a_if.done),    64'h0);
    check("rst a rd_data", 64'(a_if.rd_data), 64'h0);
    check("rst b SS_n",    64'(b_if.SS_n),    64'hF);
    check("rst b SCLK",    64'(b_if.SCLK),    64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default parameters, mode 3, MOSI looped back to MISO.
    a_if.wrt = 1'b1; a_if.cmd = 16'hA5C3; a_if.cpol = 1'b1; a_if.cpha = 1'b1;
    a_lat = -1; a_rises = 0; a_prev = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      a_if.wrt = 1'b0;
      if (k == 0) begin
        check("a busy at T0", 64'(a_if.busy), 64'h1);
        check("a SS_n at T0", 64'(a_if.SS_n), 64'h0);
        check("a MOSI at T0", 64'(a_if.MOSI), 64'h1);
        check("a SCLK at T0", 64'(a_if.SCLK), 64'h1);
      end else if (a_if.SCLK && !a_prev) begin
        a_rises++;
      end
      a_prev = a_if.SCLK;
      if (a_if.done) begin
        a_lat = k;
        check("a rd_data",    64'(a_if.rd_data), 64'hA5C3);
        check("a SS_n done",  64'(a_if.SS_n),    64'h1);
        check("a busy done",  64'(a_if.busy),    64'h0);
        check("a SCLK idle",  64'(a_if.SCLK),    64'h1);
        break;
      end
    end
    check("a done latency", 64'(a_lat),   64'(A_LAT));
    check("a SCLK rises",   64'(a_rises), 64'd16);

    // Reset midway through bit 7 of a mode-0 transfer on instance b.
    @(negedge clk);
    b_if.wrt = 1'b1; b_if.cmd = 8'hC3; b_if.ss_sel = 3'd1; b_if.cpol = 1'b0; b_if.cpha = 1'b0;
    sl_cpol = 1'b0; sl_cpha = 1'b0; sl_word = 8'h3C;
    @(negedge clk);
    b_if.wrt = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-rst SCLK before", 64'(b_if.SCLK), 64'h1);
    check("mid-rst busy before", 64'(b_if.busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid-rst SS_n",    64'(b_if.SS_n),    64'hF);
    check("mid-rst SCLK",    64'(b_if.SCLK),    64'h0);
    check("mid-rst busy",    64'(b_if.busy),    64'h0);
    check("mid-rst done",    64'(b_if.done),    64'h0);
    check("mid-rst rd_data", 64'(b_if.rd_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      xfer(vecs[i], -1, lat, sclk_first, ss_first, ss_and, sclk_end, ss_end, rd);
      check($sformatf("v%0d latency", i),    64'(lat),        64'(B_LAT));
      check($sformatf("v%0d SCLK start", i), 64'(sclk_first), 64'(vecs[i].cpol));
      check($sformatf("v%0d SCLK end", i),   64'(sclk_end),   64'(vecs[i].cpol));
      check($sformatf("v%0d SS_n active", i), 64'(ss_and),    64'(vecs[i].exp_ss_n));
      check($sformatf("v%0d SS_n done", i),  64'(ss_end),     64'hF);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d rd_data", i),  64'(rd),         64'(vecs[i].word));
        check($sformatf("v%0d slave rx", i), 64'(sl_rx),      64'(vecs[i].cmd));
      end
      @(negedge clk);
      check($sformatf("v%0d done width", i), 64'(b_if.done), 64'h0);
    end

    // wrt pulsed again mid-transfer with a different cmd and select.
    v_rep = '{1'b0, 1'b1, 3'd2, 8'h5A, 8'h3C, 4'hB, 1'b1};
    xfer(v_rep, 10, lat, sclk_first, ss_first, ss_and, sclk_end, ss_end, rd);
    check("repulse latency",  64'(lat),    64'(B_LAT));
    check("repulse rd_data",  64'(rd),     64'h3C);
    check("repulse slave rx", 64'(sl_rx),  64'h5A);
    check("repulse SS_n",     64'(ss_and), 64'hB);
    @(negedge clk);

    // Back-to-back: second wrt driven during the done cycle.
    v_b2b = '{1'b1, 1'b0, 3'd0, 8'hE7, 8'h3C, 4'hE, 1'b1};
    xfer(vecs[3], -1, lat, sclk_first, ss_first, ss_and, sclk_end, ss_end, rd);
    xfer(v_b2b, -1, lat2, sclk_first, ss_first2, ss_and2, sclk_end, ss_end2, rd2);
    check("b2b first latency",   64'(lat),       64'(B_LAT));
    check("b2b first rd_data",   64'(rd),        64'h3C);
    check("b2b gap SS_n",        64'(ss_end),    64'hF);
    check("b2b second SS_n T0",  64'(ss_first2), 64'hE);
    check("b2b second latency",  64'(lat2),      64'(B_LAT));
    check("b2b second rd_data",  64'(rd2),       64'h3C);
    check("b2b second slave rx", 64'(sl_rx),     64'hE7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
